// File: rtl/pe_seq_pkg.sv
// Shared types and default sizing for the processing-element sequencer.
// The controller, its interface and the watchdog all import this package.
package pe_seq_pkg;

    localparam int DEF_DW  = 16;
    localparam int DEF_CW  = 8;
    localparam int DEF_TMO = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Host-side bundle of the sequencer: command, operand stream and result handshakes.
// The master modport is the host side; the slave modport is the sequencer side.
interface pe_seq_ctrl_if
    import pe_seq_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CW-1:0]        cmd_len;

    logic                 op_valid;
    logic                 op_ready;
    logic signed [DW-1:0] op_a;
    logic signed [DW-1:0] op_b;

    logic                 res_valid;
    logic                 res_ready;
    logic signed [DW-1:0] res_sum;
    logic                 res_sat;
    logic                 res_err;

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_sum, res_sat, res_err
    );

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_sum, res_sat, res_err
    );

endinterface

// File: rtl/pe_seq_tmr.sv
// Watchdog counter for the wait-for-result phase.
// Counts enabled cycles from zero and sticks at TMO, where expired is raised.
module pe_seq_tmr
    import pe_seq_pkg::*;
#(
    parameter int TMO = DEF_TMO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW    = $clog2(TMO + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TMO);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one systolic PE: takes a dot-product command, streams operand pairs
// into the PE FIFOs, then returns the PE's final sum on a valid/ready result port.
module pe_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int CW  = DEF_CW,
    parameter int TMO = DEF_TMO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pe_seq_ctrl_if.slave         host,
    output logic signed [DW-1:0] pe_a_in,
    output logic signed [DW-1:0] pe_b_in,
    output logic                 pe_awe,
    output logic                 pe_bwe,
    input  logic                 pe_aff,
    input  logic                 pe_bff,
    output logic [CW-1:0]        pe_max_cntr,
    input  logic                 pe_fout,
    input  logic                 pe_sat,
    input  logic signed [DW-1:0] pe_s_out,
    output logic                 busy
);

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        rem;
    logic                 op_ready_int;
    logic                 fire;
    logic                 tmr_clear;
    logic                 tmr_en;
    logic                 tmr_expired;
    logic signed [DW-1:0] res_sum_q;
    logic                 res_sat_q;
    logic                 res_err_q;

    // Almost-full leaves room for exactly the one registered write still in flight.
    assign op_ready_int = (state == FEED) && !pe_aff && !pe_bff;
    assign fire         = host.op_valid && op_ready_int;

    assign host.op_ready  = op_ready_int;
    assign host.cmd_ready = (state == IDLE);
    assign host.res_valid = (state == HOLD);
    assign host.res_sum   = res_sum_q;
    assign host.res_sat   = res_sat_q;
    assign host.res_err   = res_err_q;
    assign busy           = (state != IDLE);

    pe_seq_tmr #(
        .TMO (TMO)
    ) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (host.cmd_valid) begin
                    state_nxt = (host.cmd_len == '0) ? HOLD : FEED;
                end
            end
            FEED: begin
                if (fire && rem == CW'(1)) begin
                    state_nxt = WAIT;
                    tmr_clear = 1'b1;
                end
            end
            WAIT: begin
                tmr_en = 1'b1;
                if (pe_fout || tmr_expired) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (host.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A real PE sum always beats a watchdog expiry landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem         <= '0;
            pe_max_cntr <= '0;
            pe_a_in     <= '0;
            pe_b_in     <= '0;
            pe_awe      <= 1'b0;
            pe_bwe      <= 1'b0;
            res_sum_q   <= '0;
            res_sat_q   <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            pe_awe <= fire;
            pe_bwe <= fire;
            if (fire) begin
                pe_a_in <= host.op_a;
                pe_b_in <= host.op_b;
                rem     <= rem - 1'b1;
            end
            if (state == IDLE && host.cmd_valid) begin
                pe_max_cntr <= host.cmd_len;
                rem         <= host.cmd_len;
                if (host.cmd_len == '0) begin
                    res_sum_q <= '0;
                    res_sat_q <= 1'b0;
                    res_err_q <= 1'b1;
                end
            end
            if (state == WAIT) begin
                if (pe_fout) begin
                    res_sum_q <= pe_s_out;
                    res_sat_q <= pe_sat;
                    res_err_q <= 1'b0;
                end else if (tmr_expired) begin
                    res_sum_q <= '0;
                    res_sat_q <= 1'b0;
                    res_err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: a cycle-level behavioural model is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_pe_seq_ctrl;

    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int TMO = 16;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [DW-1:0] pe_a_in;
    logic signed [DW-1:0] pe_b_in;
    logic                 pe_awe;
    logic                 pe_bwe;
    logic                 pe_aff;
    logic                 pe_bff;
    logic [CW-1:0]        pe_max_cntr;
    logic                 pe_fout;
    logic                 pe_sat;
    logic signed [DW-1:0] pe_s_out;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    pe_seq_ctrl_if #(.DW(DW), .CW(CW)) host ();

    pe_seq_ctrl #(
        .DW  (DW),
        .CW  (CW),
        .TMO (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host),
        .pe_a_in     (pe_a_in),
        .pe_b_in     (pe_b_in),
        .pe_awe      (pe_awe),
        .pe_bwe      (pe_bwe),
        .pe_aff      (pe_aff),
        .pe_bff      (pe_bff),
        .pe_max_cntr (pe_max_cntr),
        .pe_fout     (pe_fout),
        .pe_sat      (pe_sat),
        .pe_s_out    (pe_s_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 streaming, 2 awaiting sum, 3 result held.
    int m_phase = 0, m_left = 0, m_elapsed = 0, m_max = 0;
    int m_a = 0, m_b = 0, m_sum = 0, m_sat = 0, m_err = 0, cyc_cnt = 0;
    bit m_we = 0, m_fire = 0, started = 0;

    always @(posedge clk) begin
        cyc_cnt++;
        m_fire = 0;
        m_we   = 0;
        if (!rst_n) begin
            started = 1;
            m_phase = 0; m_left = 0; m_elapsed = 0; m_max = 0;
            m_a = 0; m_b = 0; m_sum = 0; m_sat = 0; m_err = 0;
        end else begin
            case (m_phase)
                0: if (host.cmd_valid) begin
                    m_max  = host.cmd_len;
                    m_left = host.cmd_len;
                    if (m_left == 0) begin
                        m_phase = 3; m_err = 1; m_sum = 0; m_sat = 0;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (host.op_valid && !pe_aff && !pe_bff) begin
                    m_fire = 1; m_we = 1;
                    m_a = host.op_a; m_b = host.op_b;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2; m_elapsed = 0;
                    end
                end
                2: if (pe_fout) begin
                    m_sum = pe_s_out; m_sat = pe_sat; m_err = 0; m_phase = 3;
                end else if (m_elapsed == TMO) begin
                    m_sum = 0; m_sat = 0; m_err = 1; m_phase = 3;
                end else begin
                    m_elapsed++;
                end
                3: if (host.res_ready) m_phase = 0;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("cmd_ready", host.cmd_ready, m_phase == 0);
            checkOutput("busy", busy, m_phase != 0);
            checkOutput("op_ready", host.op_ready, (m_phase == 1) && !pe_aff && !pe_bff);
            checkOutput("pe_awe", pe_awe, m_we);
            checkOutput("pe_bwe", pe_bwe, m_we);
            checkOutput("pe_a_in", pe_a_in, m_a);
            checkOutput("pe_b_in", pe_b_in, m_b);
            checkOutput("pe_max_cntr", pe_max_cntr, m_max);
            checkOutput("res_valid", host.res_valid, m_phase == 3);
            if (m_phase == 3) begin
                checkOutput("res_sum", host.res_sum, m_sum);
                checkOutput("res_sat", host.res_sat, m_sat);
                checkOutput("res_err", host.res_err, m_err);
            end
        end
    end

    int wr_a[$], wr_b[$], wr_cyc[$];

    always @(negedge clk) begin
        if (started && pe_awe === 1'b1) begin
            wr_a.push_back(int'(pe_a_in));
            wr_b.push_back(int'(pe_b_in));
            wr_cyc.push_back(cyc_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        wr_a.delete();
        wr_b.delete();
        wr_cyc.delete();
    endtask

    task automatic sendCmd(input int len);
        host.cmd_valid = 1'b1;
        host.cmd_len   = CW'(len);
        tick();
        host.cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int base_a, input int base_b,
                                 input int stall_at, input int stall_len);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            host.op_valid = 1'b1;
            host.op_a     = DW'(base_a + i);
            host.op_b     = DW'(base_b + i);
            if (i == stall_at) begin
                pe_aff = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    checkOutput("stall_op_ready", host.op_ready, 0);
                    checkOutput("stall_awe", pe_awe, 0);
                end
                pe_aff = 1'b0;
            end
            do begin
                tick();
                guard++;
            end while (!m_fire && guard < 64);
            checkOutput("op_accept", m_fire, 1);
        end
        host.op_valid = 1'b0;
    endtask

    task automatic pulseFout(input int sum, input int sat);
        pe_fout  = 1'b1;
        pe_s_out = DW'(sum);
        pe_sat   = sat[0];
        tick();
        pe_fout  = 1'b0;
        pe_sat   = 1'b0;
    endtask

    task automatic waitResult(input int budget, output int cyc);
        cyc = 0;
        while (host.res_valid !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        checkOutput("res_valid_seen", host.res_valid, 1);
    endtask

    task automatic handoff();
        host.res_ready = 1'b1;
        tick();
        host.res_ready = 1'b0;
    endtask

    task automatic checkLog(input string tag, input int n, input int a0, input int b0, input int span);
        checkOutput({tag, "_write_count"}, wr_a.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_write_a"}, (i < wr_a.size()) ? wr_a[i] : -99999, a0 + i);
            checkOutput({tag, "_write_b"}, (i < wr_b.size()) ? wr_b[i] : -99999, b0 + i);
        end
        if (wr_cyc.size() == n && n > 0)
            checkOutput({tag, "_write_span"}, wr_cyc[n-1] - wr_cyc[0], span);
    endtask

    initial begin
        int cyc;
        host.cmd_valid = 1'b0; host.cmd_len = '0;
        host.op_valid  = 1'b0; host.op_a = '0; host.op_b = '0;
        host.res_ready = 1'b0;
        pe_aff = 1'b0; pe_bff = 1'b0; pe_fout = 1'b0; pe_sat = 1'b0; pe_s_out = '0;

        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        checkOutput("reset_cmd_ready", host.cmd_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_res_valid", host.res_valid, 0);
        checkOutput("reset_awe", pe_awe, 0);
        checkOutput("reset_max_cntr", pe_max_cntr, 0);

        $display("[TB] scenario 1: four pairs, continuous stream");
        clearLog();
        sendCmd(4);
        checkOutput("t1_max_cntr", pe_max_cntr, 4);
        applyStimulus(4, 1, 5, -1, 0);
        tick();
        pulseFout(70, 0);
        waitResult(8, cyc);
        checkOutput("t1_latency", cyc, 0);
        checkOutput("t1_sum", host.res_sum, 70);
        checkOutput("t1_sat", host.res_sat, 0);
        checkOutput("t1_err", host.res_err, 0);
        checkLog("t1", 4, 1, 5, 3);
        handoff();

        $display("[TB] scenario 2: A FIFO almost-full stall after two pairs");
        clearLog();
        sendCmd(4);
        applyStimulus(4, 1, 5, 2, 3);
        tick();
        pulseFout(70, 0);
        waitResult(8, cyc);
        checkOutput("t2_sum", host.res_sum, 70);
        checkLog("t2", 4, 1, 5, 6);
        handoff();

        $display("[TB] scenario 3: zero-length command");
        clearLog();
        sendCmd(0);
        waitResult(4, cyc);
        checkOutput("t3_latency", cyc, 0);
        checkOutput("t3_err", host.res_err, 1);
        checkOutput("t3_sum", host.res_sum, 0);
        checkOutput("t3_sat", host.res_sat, 0);
        repeat (2) tick();
        checkOutput("t3_write_count", wr_a.size(), 0);
        checkOutput("t3_max_cntr", pe_max_cntr, 0);
        handoff();

        $display("[TB] scenario 4a: watchdog timeout");
        sendCmd(2);
        applyStimulus(2, 100, 200, -1, 0);
        waitResult(40, cyc);
        checkOutput("t4_timeout_latency", cyc, 17);
        checkOutput("t4_err", host.res_err, 1);
        checkOutput("t4_sum", host.res_sum, 0);
        handoff();

        $display("[TB] scenario 4b: final sum arrives on the expiry cycle");
        sendCmd(2);
        applyStimulus(2, 100, 200, -1, 0);
        repeat (16) tick();
        pulseFout(1234, 0);
        waitResult(4, cyc);
        checkOutput("t4b_latency", cyc, 0);
        checkOutput("t4b_err", host.res_err, 0);
        checkOutput("t4b_sum", host.res_sum, 1234);
        handoff();

        $display("[TB] scenario 5: saturated sum held under back-pressure");
        sendCmd(1);
        applyStimulus(1, -1, 2, -1, 0);
        tick();
        pulseFout(-32768, 1);
        host.op_valid  = 1'b1;
        host.cmd_valid = 1'b1;
        host.cmd_len   = '0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t5_res_valid", host.res_valid, 1);
            checkOutput("t5_sum", host.res_sum, -32768);
            checkOutput("t5_sat", host.res_sat, 1);
            checkOutput("t5_cmd_ready", host.cmd_ready, 0);
            checkOutput("t5_busy", busy, 1);
            checkOutput("t5_op_ready", host.op_ready, 0);
            if (k == 1) begin
                pe_fout  = 1'b1;
                pe_s_out = DW'(5);
            end
            tick();
            pe_fout = 1'b0;
        end
        host.op_valid = 1'b0;
        handoff();
        host.cmd_valid = 1'b0;
        checkOutput("t5_after_handoff_cmd_ready", host.cmd_ready, 1);
        checkOutput("t5_after_handoff_res_valid", host.res_valid, 0);
        tick();
        checkOutput("t5_no_early_accept", busy, 0);

        $display("[TB] scenario 6: reset mid-stream, then a fresh command");
        clearLog();
        sendCmd(4);
        applyStimulus(2, 1, 5, -1, 0);
        rst_n = 1'b0;
        tick();
        checkOutput("t6_cmd_ready", host.cmd_ready, 1);
        checkOutput("t6_awe", pe_awe, 0);
        checkOutput("t6_bwe", pe_bwe, 0);
        checkOutput("t6_max_cntr", pe_max_cntr, 0);
        checkOutput("t6_res_valid", host.res_valid, 0);
        checkOutput("t6_busy", busy, 0);
        rst_n = 1'b1;
        clearLog();
        sendCmd(3);
        checkOutput("t6_new_max_cntr", pe_max_cntr, 3);
        applyStimulus(3, 10, -3, -1, 0);
        tick();
        pulseFout(-5, 0);
        waitResult(8, cyc);
        checkOutput("t6_sum", host.res_sum, -5);
        checkOutput("t6_err", host.res_err, 0);
        checkLog("t6", 3, 10, -3, 2);
        handoff();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
